// File: rtl/compare_pkg.sv
// ----------------------------------------------------------------------------
// compare_pkg : shared state encoding and default sizing for compare_scan_ctrl
// Revision    : 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package compare_pkg;

  localparam int DEF_WIDTH = 4;
  localparam int DEF_DEPTH = 8;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COLLECT = 2'd1,
    ST_DONE    = 2'd2
  } state_e;

endpackage

`default_nettype wire

// File: rtl/cmp_core.sv
// ----------------------------------------------------------------------------
// cmp_core : combinational unsigned comparator of one operand against the
//            running max (gt/eq) and the running min (lt)
// Revision : 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module cmp_core #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b_max,
  input  logic [WIDTH-1:0] b_min,
  output logic             gt,
  output logic             lt,
  output logic             eq
);

  assign gt = (a > b_max);
  assign lt = (a < b_min);
  assign eq = (a == b_max);

endmodule

`default_nettype wire

// File: rtl/compare_scan_ctrl.sv
// ----------------------------------------------------------------------------
// compare_scan_ctrl : frame sequencer tracking max/min, first-occurrence
//                     indices and beat count, with a held result handshake
// Revision          : 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module compare_scan_ctrl
  import compare_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DEPTH = DEF_DEPTH,
  parameter int IDX_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_last,
  output logic             in_ready,
  output logic             busy,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [WIDTH-1:0] res_max,
  output logic [WIDTH-1:0] res_min,
  output logic [IDX_W-1:0] res_max_idx,
  output logic [IDX_W-1:0] res_min_idx,
  output logic [IDX_W:0]   res_count,
  output logic             res_all_eq,
  output logic             res_trunc
);

  localparam int             CNT_W    = IDX_W + 1;
  localparam logic [IDX_W:0] LAST_CNT = CNT_W'(DEPTH - 1);
  localparam logic [IDX_W:0] CNT_ONE  = CNT_W'(1);

  state_e state_q, state_d;

  logic [WIDTH-1:0] max_q, max_d, min_q, min_d;
  logic [IDX_W-1:0] max_idx_q, max_idx_d, min_idx_q, min_idx_d;
  logic [IDX_W:0]   cnt_q, cnt_d;
  logic             eq_q, eq_d;

  logic [WIDTH-1:0] res_max_q, res_max_d, res_min_q, res_min_d;
  logic [IDX_W-1:0] res_max_idx_q, res_max_idx_d, res_min_idx_q, res_min_idx_d;
  logic [IDX_W:0]   res_count_q, res_count_d;
  logic             res_all_eq_q, res_all_eq_d, res_trunc_q, res_trunc_d;

  logic w_gt, w_lt, w_eq;

  cmp_core #(.WIDTH(WIDTH)) u_cmp (
    .a     (in_data),
    .b_max (max_q),
    .b_min (min_q),
    .gt    (w_gt),
    .lt    (w_lt),
    .eq    (w_eq)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      max_q         <= '0;
      min_q         <= '0;
      max_idx_q     <= '0;
      min_idx_q     <= '0;
      cnt_q         <= '0;
      eq_q          <= 1'b0;
      res_max_q     <= '0;
      res_min_q     <= '0;
      res_max_idx_q <= '0;
      res_min_idx_q <= '0;
      res_count_q   <= '0;
      res_all_eq_q  <= 1'b0;
      res_trunc_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      max_q         <= max_d;
      min_q         <= min_d;
      max_idx_q     <= max_idx_d;
      min_idx_q     <= min_idx_d;
      cnt_q         <= cnt_d;
      eq_q          <= eq_d;
      res_max_q     <= res_max_d;
      res_min_q     <= res_min_d;
      res_max_idx_q <= res_max_idx_d;
      res_min_idx_q <= res_min_idx_d;
      res_count_q   <= res_count_d;
      res_all_eq_q  <= res_all_eq_d;
      res_trunc_q   <= res_trunc_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    max_d         = max_q;
    min_d         = min_q;
    max_idx_d     = max_idx_q;
    min_idx_d     = min_idx_q;
    cnt_d         = cnt_q;
    eq_d          = eq_q;
    res_max_d     = res_max_q;
    res_min_d     = res_min_q;
    res_max_idx_d = res_max_idx_q;
    res_min_idx_d = res_min_idx_q;
    res_count_d   = res_count_q;
    res_all_eq_d  = res_all_eq_q;
    res_trunc_d   = res_trunc_q;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_COLLECT;
          cnt_d   = '0;
        end
      end

      ST_COLLECT: begin
        if (in_valid) begin
          cnt_d = cnt_q + CNT_ONE;
          if (cnt_q == '0) begin
            max_d     = in_data;
            min_d     = in_data;
            max_idx_d = '0;
            min_idx_d = '0;
            eq_d      = 1'b1;
          end else begin
            // Strict compares: ties keep the earliest index.
            if (w_gt) begin
              max_d     = in_data;
              max_idx_d = cnt_q[IDX_W-1:0];
            end
            if (w_lt) begin
              min_d     = in_data;
              min_idx_d = cnt_q[IDX_W-1:0];
            end
            // Max only grows and min only shrinks, so equality can only be lost.
            eq_d = eq_q & w_eq;
          end

          if (in_last || (cnt_q == LAST_CNT)) begin
            state_d       = ST_DONE;
            res_max_d     = max_d;
            res_min_d     = min_d;
            res_max_idx_d = max_idx_d;
            res_min_idx_d = min_idx_d;
            res_count_d   = cnt_d;
            res_all_eq_d  = eq_d;
            res_trunc_d   = ~in_last;
          end
        end
      end

      ST_DONE: begin
        if (res_ready) begin
          state_d = ST_IDLE;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  assign in_ready    = (state_q == ST_COLLECT);
  assign busy        = (state_q != ST_IDLE);
  assign res_valid   = (state_q == ST_DONE);
  assign res_max     = res_max_q;
  assign res_min     = res_min_q;
  assign res_max_idx = res_max_idx_q;
  assign res_min_idx = res_min_idx_q;
  assign res_count   = res_count_q;
  assign res_all_eq  = res_all_eq_q;
  assign res_trunc   = res_trunc_q;

endmodule

`default_nettype wire

// File: tb/tb_compare_scan_ctrl.sv
// ----------------------------------------------------------------------------
// tb_compare_scan_ctrl : directed scoreboard bench for compare_scan_ctrl
// Revision             : 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_compare_scan_ctrl;

  logic       clk = 1'b0;
  logic       rst_n, start, in_valid, in_last, res_ready;
  logic [3:0] in_data;
  logic       in_ready, busy, res_valid, res_all_eq, res_trunc;
  logic [3:0] res_max, res_min, res_count;
  logic [2:0] res_max_idx, res_min_idx;

  compare_scan_ctrl #(.WIDTH(4), .DEPTH(8), .IDX_W(3)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .in_valid    (in_valid),
    .in_data     (in_data),
    .in_last     (in_last),
    .in_ready    (in_ready),
    .busy        (busy),
    .res_valid   (res_valid),
    .res_ready   (res_ready),
    .res_max     (res_max),
    .res_min     (res_min),
    .res_max_idx (res_max_idx),
    .res_min_idx (res_min_idx),
    .res_count   (res_count),
    .res_all_eq  (res_all_eq),
    .res_trunc   (res_trunc)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0] mx;
    logic [3:0] mn;
    logic [2:0] mxi;
    logic [2:0] mni;
    logic [3:0] cnt;
    logic       eq;
    logic       tr;
  } exp_t;

  exp_t       exp_q[$];
  logic [3:0] frame [8];
  int         checks = 0;
  int         errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic push_model(input int n, input bit mark_last);
    exp_t e;
    e.mx = frame[0]; e.mn = frame[0]; e.mxi = '0; e.mni = '0;
    for (int i = 1; i < n; i++) begin
      if (frame[i] > e.mx) begin e.mx = frame[i]; e.mxi = 3'(i); end
      if (frame[i] < e.mn) begin e.mn = frame[i]; e.mni = 3'(i); end
    end
    e.cnt = 4'(n);
    e.eq  = (e.mx == e.mn);
    e.tr  = !mark_last && (n == 8);
    exp_q.push_back(e);
  endtask

  task automatic send_frame(input int n, input bit mark_last, input bit gaps);
    push_model(n, mark_last);
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    chk("busy_after_start", busy, 1'b1);
    chk("in_ready_collect", in_ready, 1'b1);
    for (int i = 0; i < n; i++) begin
      if (gaps && (i % 2 == 1)) begin
        in_valid = 1'b0; start = 1'b1; in_data = 4'hF;
        @(negedge clk); start = 1'b0;
      end
      in_valid = 1'b1; in_data = frame[i]; in_last = mark_last && (i == n - 1);
      @(negedge clk);
    end
    in_valid = 1'b0; in_last = 1'b0;
    chk("res_valid_latency", res_valid, 1'b1);
    chk("in_ready_done", in_ready, 1'b0);
  endtask

  task automatic collect(input int hold);
    exp_t e;
    int   w = 0;
    while (!res_valid && w < 10) begin @(negedge clk); w++; end
    chk("res_valid_wait", res_valid, 1'b1);
    if (exp_q.size() == 0) begin
      chk("scoreboard_nonempty", 32'd0, 32'd1);
      e = '0;
    end else begin
      e = exp_q.pop_front();
    end
    for (int h = 0; h <= hold; h++) begin
      chk("res_max",     res_max,     e.mx);
      chk("res_min",     res_min,     e.mn);
      chk("res_max_idx", res_max_idx, e.mxi);
      chk("res_min_idx", res_min_idx, e.mni);
      chk("res_count",   res_count,   e.cnt);
      chk("res_all_eq",  res_all_eq,  e.eq);
      chk("res_trunc",   res_trunc,   e.tr);
      chk("res_valid_held", res_valid, 1'b1);
      if (h < hold) @(negedge clk);
    end
    res_ready = 1'b1;
    @(negedge clk); res_ready = 1'b0;
    chk("res_valid_drop", res_valid, 1'b0);
    chk("busy_idle", busy, 1'b0);
    chk("res_max_retained", res_max, e.mx);
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; in_valid = 1'b0; in_last = 1'b0;
    res_ready = 1'b0; in_data = '0;
    repeat (2) @(negedge clk);
    chk("rst_in_ready", in_ready, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_res_valid", res_valid, 1'b0);
    chk("rst_fields", {res_max, res_min, res_max_idx, res_min_idx, res_count, res_all_eq, res_trunc}, '0);
    rst_n = 1'b1;
    @(negedge clk);

    // Beat offered in IDLE must not be taken.
    in_valid = 1'b1; in_data = 4'h3;
    @(negedge clk);
    chk("idle_in_ready", in_ready, 1'b0);
    in_valid = 1'b0;

    frame = '{4'd3, 4'd9, 4'd1, 4'd9, 4'd0, 4'd0, 4'd0, 4'd0};
    send_frame(4, 1'b1, 1'b0);
    collect(0);

    frame = '{4'd5, 4'd5, 4'd5, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0};
    send_frame(3, 1'b1, 1'b0);
    collect(0);

    frame = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7};
    send_frame(8, 1'b0, 1'b0);
    in_valid = 1'b1; in_data = 4'd9; in_last = 1'b1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("trunc_no_consume", in_ready, 1'b0);
    @(negedge clk);
    chk("trunc_still_done", res_valid, 1'b1);
    in_valid = 1'b0; in_last = 1'b0;
    collect(0);
    chk("after_trunc_in_ready", in_ready, 1'b0);

    frame = '{4'hF, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0};
    send_frame(1, 1'b1, 1'b0);
    collect(5);

    frame = '{4'd6, 4'd2, 4'd8, 4'd2, 4'd0, 4'd0, 4'd0, 4'd0};
    send_frame(4, 1'b1, 1'b1);
    collect(0);

    // Asynchronous reset mid-frame discards the frame.
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0; in_valid = 1'b1; in_data = 4'd7;
    @(negedge clk); in_data = 4'd1;
    @(negedge clk); in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_busy", busy, 1'b0);
    chk("midrst_valid", res_valid, 1'b0);
    chk("midrst_fields", {res_max, res_min, res_max_idx, res_min_idx, res_count, res_all_eq, res_trunc}, '0);
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);
    chk("midrst_no_result", res_valid, 1'b0);

    frame = '{4'd2, 4'd4, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0};
    send_frame(2, 1'b1, 1'b0);
    collect(0);

    chk("scoreboard_empty", exp_q.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire
